imem_fetch_port: RTL and testbench

Parametrised, synchronous instruction memory with a valid/ready fetch handshake, a programming write port, and address-fault detection. It sits between the core's fetch stage and instruction storage. It replaces the combinational instruction ROM with a registered one-cycle read, backpressure support and in-system reloading.

---
 rtl/imem_pkg.sv | 21 ++
 rtl/imem_ram_1r1w.sv | 29 ++
 rtl/imem_fetch_port.sv | 118 +++++++++++
 tb/tb_imem_fetch_port.sv | 345 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared constants and types for the instruction-memory fetch port.
package imem_pkg;

    localparam logic [31:0] NOP_INS = 32'h00000013;

    typedef enum logic [1:0] {
        FAULT_NONE     = 2'b00,
        FAULT_MISALIGN = 2'b01,
        FAULT_RANGE    = 2'b10
    } imem_fault_t;

    // Source of the word presented on resp_ins.
    typedef enum logic [1:0] {
        INS_ZERO = 2'b00,
        INS_RAM  = 2'b01,
        INS_NOP  = 2'b10
    } imem_ins_src_t;

    localparam int FAULT_CNT_W = 16;

endpackage

// File: rtl/imem_ram_1r1w.sv
// Synchronous-read, single-write word RAM.
module imem_ram_1r1w #(
  parameter int    DEPTH_WORDS = 1024,
  parameter string INIT_FILE   = "",
  parameter int    DATA_W      = 32,
  parameter int    ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // Stage p0 -> p1: registered read, single write port.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/imem_fetch_port.sv
// Registered instruction fetch port: valid/ready handshake, fault decode, program port.
// Optional saturating fault counter enabled by defining IMEM_FAULT_CNT_EN.
module imem_fetch_port
    import imem_pkg::*;
#(
    parameter int    DEPTH_WORDS = 1024,
    parameter string INIT_FILE   = ""
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_ins,
    output logic [1:0]  resp_fault,
    input  logic        prog_we,
    input  logic [31:0] prog_addr,
    input  logic [31:0] prog_data
`ifdef IMEM_FAULT_CNT_EN
    ,
    output logic [15:0] fault_count
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    function automatic imem_fault_t classify(input logic [31:0] addr);
        if (addr[1:0] != 2'b00) begin
            return FAULT_MISALIGN;
        end
        if (addr[31:IDX_W+2] != '0) begin
            return FAULT_RANGE;
        end
        return FAULT_NONE;
    endfunction

    function automatic logic [FAULT_CNT_W-1:0] sat_inc(input logic [FAULT_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    imem_fault_t   fault_p0;
    logic          accept_p0;
    logic          rd_en_p0;
    logic          wr_en_p0;
    logic          vld_p1;
    imem_fault_t   fault_p1;
    imem_ins_src_t src_p1;
    logic [31:0]   ram_q;
    logic          unused_prog_lsb;

    assign unused_prog_lsb = ^prog_addr[1:0];

    // Stage p0: handshake and address decode.
    assign req_ready = !prog_we && (!vld_p1 || resp_ready);
    assign accept_p0 = req_valid && req_ready;
    assign fault_p0  = classify(req_addr);
    assign rd_en_p0  = accept_p0 && (fault_p0 == FAULT_NONE);
    assign wr_en_p0  = prog_we && (prog_addr[31:IDX_W+2] == '0);

    imem_ram_1r1w #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .INIT_FILE  (INIT_FILE),
        .DATA_W     (32),
        .ADDR_W     (IDX_W)
    ) u_ram (
        .clk    (clk),
        .rd_en  (rd_en_p0),
        .rd_addr(req_addr[IDX_W+1:2]),
        .rd_data(ram_q),
        .wr_en  (wr_en_p0),
        .wr_addr(prog_addr[IDX_W+1:2]),
        .wr_data(prog_data)
    );

    // Stage p1: response register; the instruction word itself lives in the RAM output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p1   <= 1'b0;
            fault_p1 <= FAULT_NONE;
            src_p1   <= INS_ZERO;
        end else if (accept_p0) begin
            vld_p1   <= 1'b1;
            fault_p1 <= fault_p0;
            src_p1   <= (fault_p0 == FAULT_NONE) ? INS_RAM : INS_NOP;
        end else if (resp_ready) begin
            vld_p1   <= 1'b0;
        end
    end

    always_comb begin
        resp_ins = '0;
        unique case (src_p1)
            INS_RAM:  resp_ins = ram_q;
            INS_NOP:  resp_ins = NOP_INS;
            default:  resp_ins = '0;
        endcase
    end

    assign resp_valid = vld_p1;
    assign resp_fault = fault_p1;

`ifdef IMEM_FAULT_CNT_EN
    logic [FAULT_CNT_W-1:0] fault_cnt_p1;

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_cnt_p1 <= '0;
        end else if (accept_p0 && (fault_p0 != FAULT_NONE)) begin
            fault_cnt_p1 <= sat_inc(fault_cnt_p1);
        end
    end

    assign fault_count = fault_cnt_p1;
`endif

endmodule

// File: tb/tb_imem_fetch_port.sv
// Randomised self-checking bench for imem_fetch_port against a word-array reference model.
module tb_imem_fetch_port;

    localparam int DEPTH = 64;
    localparam logic [31:0] NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_ins;
    logic [1:0]  resp_fault;
    logic        prog_we;
    logic [31:0] prog_addr;
    logic [31:0] prog_data;
`ifdef IMEM_FAULT_CNT_EN
    logic [15:0] fault_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] mem_model [DEPTH];

    imem_fetch_port #(.DEPTH_WORDS(DEPTH), .INIT_FILE("")) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr   (req_addr),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_ins   (resp_ins),
        .resp_fault (resp_fault),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data)
`ifdef IMEM_FAULT_CNT_EN
        ,
        .fault_count(fault_count)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [1:0] model_fault(input logic [31:0] a);
        if (a % 4 != 0) return 2'b01;
        if ((a / 4) >= DEPTH) return 2'b10;
        return 2'b00;
    endfunction

    function automatic logic [31:0] model_ins(input logic [31:0] a);
        if (model_fault(a) != 2'b00) return NOP;
        return mem_model[a / 4];
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic prog_write(input logic [31:0] a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        step();
        prog_we = 1'b0;
        if ((a / 4) < DEPTH) mem_model[a / 4] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        req_valid = 1'b0; req_addr = '0; resp_ready = 1'b1;
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        do_reset();
        n_tests++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
        n_tests++;
        if (resp_ins !== 32'h0) begin n_fail++; $display("FAIL reset_ins: got %h want 00000000", resp_ins); end
        n_tests++;
        if (resp_fault !== 2'b00) begin n_fail++; $display("FAIL reset_fault: got %b want 00", resp_fault); end
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", req_ready); end
`ifdef IMEM_FAULT_CNT_EN
        n_tests++;
        if (fault_count !== 16'h0) begin n_fail++; $display("FAIL reset_cnt: got %h want 0000", fault_count); end
`endif
    endtask

    task automatic load_image();
        for (int i = 0; i < DEPTH; i++) prog_write(32'(i * 4), $urandom);
    endtask

    task automatic test_sequential();
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = 32'(i * 4);
            step();
            n_tests++;
            if (resp_valid !== 1'b1 || resp_ins !== mem_model[i] || resp_fault !== 2'b00) begin
                n_fail++;
                $display("FAIL seq_%0d: got v=%b ins=%h f=%b want v=1 ins=%h f=00",
                         i, resp_valid, resp_ins, resp_fault, mem_model[i]);
            end
        end
        req_valid = 1'b0;
        step();
        n_tests++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL seq_drain: got v=%b want 0", resp_valid); end
    endtask

    task automatic test_backpressure();
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h4;
        step();
        req_addr = 32'h8;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_tests++;
            if (req_ready !== 1'b0 || resp_valid !== 1'b1 || resp_ins !== mem_model[1]) begin
                n_fail++;
                $display("FAIL bp_hold_%0d: got rdy=%b v=%b ins=%h want rdy=0 v=1 ins=%h",
                         i, req_ready, resp_valid, resp_ins, mem_model[1]);
            end
            step();
        end
        resp_ready = 1'b1;
        #1;
        n_tests++;
        if (req_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_rdy: got %b want 1", req_ready); end
        step();
        req_valid = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b1 || resp_ins !== mem_model[2] || resp_fault !== 2'b00) begin
            n_fail++;
            $display("FAIL bp_next: got v=%b ins=%h f=%b want v=1 ins=%h f=00",
                     resp_valid, resp_ins, resp_fault, mem_model[2]);
        end
        step();
    endtask

    task automatic test_faults();
        logic [31:0] addrs [6];
        addrs[0] = 32'h6;
        addrs[1] = 32'(DEPTH * 4);
        addrs[2] = 32'(DEPTH * 4 + 2);
        addrs[3] = 32'hFFFF_FFFC;
        addrs[4] = 32'h8000_0001;
        addrs[5] = 32'(DEPTH * 4 - 4);
        resp_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            req_valid = 1'b1;
            req_addr  = addrs[i];
            step();
            req_valid = 1'b0;
            n_tests++;
            if (resp_valid !== 1'b1 || resp_fault !== model_fault(addrs[i]) ||
                resp_ins !== model_ins(addrs[i])) begin
                n_fail++;
                $display("FAIL fault_%h: got v=%b f=%b ins=%h want v=1 f=%b ins=%h", addrs[i],
                         resp_valid, resp_fault, resp_ins, model_fault(addrs[i]), model_ins(addrs[i]));
            end
        end
        step();
    endtask

    task automatic test_program();
        resp_ready = 1'b1;
        prog_we    = 1'b1;
        prog_addr  = 32'h10;
        prog_data  = 32'hDEADBEEF;
        req_valid  = 1'b1;
        req_addr   = 32'h10;
        #1;
        n_tests++;
        if (req_ready !== 1'b0) begin n_fail++; $display("FAIL prog_blocks_rdy: got %b want 0", req_ready); end
        step();
        mem_model[4] = 32'hDEADBEEF;
        prog_we = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL prog_no_resp: got v=%b want 0", resp_valid); end
        step();
        req_valid = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b1 || resp_ins !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL prog_readback: got v=%b ins=%h want v=1 ins=deadbeef", resp_valid, resp_ins);
        end
        // Out-of-range write must leave every in-range word untouched.
        prog_write(32'(DEPTH * 4 + 16), 32'h12345678);
        req_valid = 1'b1;
        req_addr  = 32'h10;
        step();
        req_valid = 1'b0;
        n_tests++;
        if (resp_ins !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL prog_oor_drop: got ins=%h want deadbeef", resp_ins);
        end
        step();
    endtask

    task automatic test_reset_mid();
        resp_ready = 1'b0;
        req_valid  = 1'b1;
        req_addr   = 32'h6;
        step();
        req_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b0 || resp_fault !== 2'b00 || resp_ins !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_mid: got v=%b f=%b ins=%h want v=0 f=00 ins=00000000",
                     resp_valid, resp_fault, resp_ins);
        end
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_addr   = 32'h10;
        step();
        req_valid = 1'b0;
        n_tests++;
        if (resp_valid !== 1'b1 || resp_ins !== 32'hDEADBEEF) begin
            n_fail++;
            $display("FAIL rst_ram_kept: got v=%b ins=%h want v=1 ins=deadbeef", resp_valid, resp_ins);
        end
        step();
    endtask

    task automatic test_random();
        logic        m_valid = 1'b0;
        logic [31:0] m_ins   = '0;
        logic [1:0]  m_fault = '0;
        logic        exp_rdy;
        int          m_cnt = 0;
        int          kind;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            req_valid  = ($urandom_range(0, 3) != 0);
            resp_ready = ($urandom_range(0, 3) != 0);
            prog_we    = ($urandom_range(0, 7) == 0);
            kind = $urandom_range(0, 5);
            case (kind)
                0, 1, 2: req_addr = 32'($urandom_range(0, DEPTH - 1) * 4);
                3:       req_addr = 32'($urandom_range(0, DEPTH - 1) * 4 + $urandom_range(1, 3));
                4:       req_addr = 32'($urandom_range(DEPTH, DEPTH * 2) * 4);
                default: req_addr = $urandom;
            endcase
            prog_addr = 32'($urandom_range(0, DEPTH + 15) * 4 + $urandom_range(0, 3));
            prog_data = $urandom;
            #1;
            exp_rdy = !prog_we && (!m_valid || resp_ready);
            n_tests++;
            if (req_ready !== exp_rdy) begin
                n_fail++;
                $display("FAIL rnd_rdy_%0d: got %b want %b", i, req_ready, exp_rdy);
            end
            if (prog_we && (prog_addr / 4) < DEPTH) mem_model[prog_addr / 4] = prog_data;
            if (req_valid && exp_rdy) begin
                m_valid = 1'b1;
                m_ins   = model_ins(req_addr);
                m_fault = model_fault(req_addr);
                if (m_fault != 2'b00 && m_cnt < 65535) m_cnt++;
            end else if (resp_ready) begin
                m_valid = 1'b0;
            end
            step();
            n_tests++;
            if (resp_valid !== m_valid || (m_valid && (resp_ins !== m_ins || resp_fault !== m_fault))) begin
                n_fail++;
                $display("FAIL rnd_resp_%0d: got v=%b ins=%h f=%b want v=%b ins=%h f=%b",
                         i, resp_valid, resp_ins, resp_fault, m_valid, m_ins, m_fault);
            end
`ifdef IMEM_FAULT_CNT_EN
            n_tests++;
            if (fault_count !== 16'(m_cnt)) begin
                n_fail++;
                $display("FAIL rnd_cnt_%0d: got %0d want %0d", i, fault_count, m_cnt);
            end
`endif
        end
        req_valid = 1'b0;
        prog_we   = 1'b0;
        resp_ready = 1'b1;
        step();
    endtask

`ifdef IMEM_FAULT_CNT_EN
    task automatic test_fault_count();
        do_reset();
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            req_addr = (i == 1) ? 32'(DEPTH * 4) : 32'h6;
            step();
        end
        req_valid = 1'b0;
        step();
        n_tests++;
        if (fault_count !== 16'd3) begin n_fail++; $display("FAIL cnt_three: got %0d want 3", fault_count); end
        // Drive the counter to its ceiling, then one more fault must not wrap it.
        req_valid = 1'b1;
        req_addr  = 32'h1;
        for (int i = 0; i < 65532; i++) step();
        req_valid = 1'b0;
        step();
        n_tests++;
        if (fault_count !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_full: got %h want ffff", fault_count); end
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        step();
        n_tests++;
        if (fault_count !== 16'hFFFF) begin n_fail++; $display("FAIL cnt_sat: got %h want ffff", fault_count); end
    endtask
`endif

    initial begin
        test_reset();
        load_image();
        test_sequential();
        test_backpressure();
        test_faults();
        test_program();
        test_reset_mid();
        test_random();
`ifdef IMEM_FAULT_CNT_EN
        test_fault_count();
`endif
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
